// File: rtl/pipe_hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline.
// Shadows E/M/W destination timing, decides D-stage stalls/forwarding and tracks MDU busy time.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic [1:0] d_md_op,
  output logic       stall,
  output logic       f_en,
  output logic       d_en,
  output logic       e_flush,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       md_start,
  output logic       md_busy
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] TUSE_NA = 2'd3;

  logic [4:0]       e_dst_q, e_dst_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic [1:0]       e_md_q, e_md_d;
  logic [4:0]       m_dst_q, m_dst_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [4:0]       w_dst_q, w_dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_hazard, rt_hazard, md_hazard;

  // Youngest matching in-flight producer (E before M) decides whether the value is late.
  function automatic logic src_hazard(input logic [4:0] idx, input logic [1:0] tuse,
                                      input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                      input logic [4:0] m_dst, input logic [1:0] m_tnew);
    logic hz;
    hz = 1'b0;
    if (tuse != TUSE_NA && idx != 5'd0) begin
      if (e_dst == idx)      hz = (e_tnew > tuse);
      else if (m_dst == idx) hz = (m_tnew > tuse);
    end
    return hz;
  endfunction

  function automatic logic [1:0] src_fwd(input logic [4:0] idx, input logic [1:0] tuse,
                                         input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                         input logic [4:0] m_dst, input logic [1:0] m_tnew,
                                         input logic [4:0] w_dst);
    logic [1:0] sel;
    sel = 2'd0;
    if (tuse != TUSE_NA && idx != 5'd0) begin
      if (e_dst == idx)      sel = (e_tnew == 2'd0) ? 2'd1 : 2'd0;
      else if (m_dst == idx) sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
      else if (w_dst == idx) sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    md_start  = (e_md_q == MD_MULT) || (e_md_q == MD_DIV);
    md_busy   = (cnt_q != '0) || md_start;
    rs_hazard = src_hazard(d_rs, d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    rt_hazard = src_hazard(d_rt, d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    md_hazard = (d_md_op != MD_NONE) && md_busy;
    stall     = rs_hazard || rt_hazard || md_hazard;
    f_en      = ~stall;
    d_en      = ~stall;
    e_flush   = stall;
    fwd_rs    = src_fwd(d_rs, d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_rt    = src_fwd(d_rt, d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
  end

  // Slot advance: a stall drops a bubble into E while M/W keep draining.
  always_comb begin
    e_dst_d  = '0;
    e_tnew_d = '0;
    e_md_d   = MD_NONE;
    if (!stall) begin
      e_dst_d  = d_dst;
      e_tnew_d = d_tnew;
      e_md_d   = d_md_op;
    end
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    w_dst_d  = m_dst_q;
    if (e_md_q == MD_MULT)     cnt_d = CNT_W'(MULT_CYCLES);
    else if (e_md_q == MD_DIV) cnt_d = CNT_W'(DIV_CYCLES);
    else if (cnt_q != '0)      cnt_d = cnt_q - CNT_W'(1);
    else                       cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst_q  <= '0;
      e_tnew_q <= '0;
      e_md_q   <= MD_NONE;
      m_dst_q  <= '0;
      m_tnew_q <= '0;
      w_dst_q  <= '0;
      cnt_q    <= '0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      e_md_q   <= e_md_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random D-stage traffic,
// checked against a timestamp-based model of in-flight results and MDU completion time.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  logic       clk, reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_op;
  logic       stall, f_en, d_en, e_flush, md_start, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  int vecs = 0;
  int miscompares = 0;

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_op(d_md_op),
    .stall(stall), .f_en(f_en), .d_en(d_en), .e_flush(e_flush),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_start(md_start), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each in-flight producer carries the absolute cycle its result exists.
  longint now;
  longint busy_end;
  logic [4:0] me_dst, mm_dst, mw_dst;
  longint     me_ready, mm_ready;
  logic [1:0] me_md;

  function automatic longint rem(input longint ready);
    return (ready > now) ? ready - now : 0;
  endfunction

  function automatic bit ref_haz(input logic [4:0] r, input logic [1:0] tu);
    if (tu == 2'd3 || r == 5'd0) return 1'b0;
    if (me_dst == r) return rem(me_ready) > longint'(tu);
    if (mm_dst == r) return rem(mm_ready) > longint'(tu);
    return 1'b0;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] r, input logic [1:0] tu);
    if (tu == 2'd3 || r == 5'd0) return 2'd0;
    if (me_dst == r) return (rem(me_ready) == 0) ? 2'd1 : 2'd0;
    if (mm_dst == r) return (rem(mm_ready) == 0) ? 2'd2 : 2'd0;
    if (mw_dst == r) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_clear();
    me_dst = '0; me_ready = 0; me_md = '0;
    mm_dst = '0; mm_ready = 0; mw_dst = '0;
    busy_end = -1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, now);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tnew, input logic [1:0] md);
    d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_dst = dst; d_tnew = tnew; d_md_op = md;
    #1;
  endtask

  task automatic idle();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0);
  endtask

  // Compare every output against the model, then clock once and advance the model.
  task automatic step();
    bit ems, emb, est;
    ems = (me_md == 2'd1) || (me_md == 2'd2);
    emb = ems || (now <= busy_end);
    est = ref_haz(d_rs, d_tuse_rs) || ref_haz(d_rt, d_tuse_rt) || ((d_md_op != 2'd0) && emb);
    chk("stall", stall, est);
    chk("f_en", f_en, !est);
    chk("d_en", d_en, !est);
    chk("e_flush", e_flush, est);
    chk("fwd_rs", fwd_rs, ref_fwd(d_rs, d_tuse_rs));
    chk("fwd_rt", fwd_rt, ref_fwd(d_rt, d_tuse_rt));
    chk("md_start", md_start, ems);
    chk("md_busy", md_busy, emb);
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (ems) busy_end = now + longint'((me_md == 2'd1) ? MULT_CYCLES : DIV_CYCLES);
      mw_dst = mm_dst;
      mm_dst = me_dst; mm_ready = me_ready;
      if (est) begin
        me_dst = '0; me_ready = 0; me_md = '0;
      end else begin
        me_dst = d_dst; me_ready = now + 1 + longint'(d_tnew); me_md = d_md_op;
      end
    end
    now++;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    now = 0;
    model_clear();
    reset = 1'b0;

    // Post-reset state
    idle();
    chk("rst_stall", stall, 1'b0);
    chk("rst_f_en", f_en, 1'b1);
    chk("rst_md_busy", md_busy, 1'b0);
    chk("rst_md_start", md_start, 1'b0);
    step();

    // Load-use: one stall, then no forward (M result not ready yet)
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd2, 2'd0); step();
    set_d(5'd2, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0);
    chk("lu_stall1", stall, 1'b1); step();
    chk("lu_stall0", stall, 1'b0);
    chk("lu_fwd", fwd_rs, 2'd0); step();
    drain();

    // Branch after load: two stalls, then forward from W
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd2, 2'd0); step();
    set_d(5'd2, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0);
    chk("br_stall_a", stall, 1'b1); step();
    chk("br_stall_b", stall, 1'b1); step();
    chk("br_release", stall, 1'b0);
    chk("br_fwd_w", fwd_rs, 2'd3); step();
    drain();

    // ALU forward from E; register 0 never forwards
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd0, 2'd0); step();
    set_d(5'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0, 2'd0);
    chk("alu_stall", stall, 1'b0);
    chk("alu_fwd_e", fwd_rt, 2'd1);
    set_d(5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0);
    chk("alu_fwd_r0", fwd_rt, 2'd0); step();
    drain();

    // Priority: E beats M; a late E result masks a ready M
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd0, 2'd0); step();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd0, 2'd0); step();
    set_d(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0);
    chk("pri_fwd_e", fwd_rs, 2'd1); step();
    drain();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd0, 2'd0); step();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 2'd0); step();
    set_d(5'd3, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0);
    chk("pri_nostall", stall, 1'b0);
    chk("pri_fwd_0", fwd_rs, 2'd0); step();
    drain();

    // mult then mfhi; div then mfhi
    for (int k = 0; k < 2; k++) begin
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, (k == 0) ? 2'd1 : 2'd2); step();
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd0, 2'd3);
      chk("md_start_first", md_start, 1'b1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
        if (stall !== 1'b1) break;
        n++;
        step();
        chk("md_start_once", md_start, 1'b0);
      end
      chk((k == 0) ? "mult_stall_len" : "div_stall_len", 8'(n),
          (k == 0) ? 8'(MULT_CYCLES + 1) : 8'(DIV_CYCLES + 1));
      step();
      drain();
    end

    // Reset mid-divide at cnt=7
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd2); step();
    idle();
    repeat (4) step();
    chk("div_busy_mid", md_busy, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    set_d(5'd2, 2'd0, 5'd3, 2'd0, 5'd0, 2'd0, 2'd3);
    chk("rst_mid_busy", md_busy, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_fwd_rs", fwd_rs, 2'd0);
    chk("rst_mid_fwd_rt", fwd_rt, 2'd0);
    step();

    // Random traffic over a small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      logic [1:0] md;
      n = int'($urandom_range(0, 15));
      md = (n == 0) ? 2'd1 : (n == 1) ? 2'd2 : (n == 2) ? 2'd3 : 2'd0;
      reset = ($urandom_range(0, 99) == 0);
      set_d(5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), md);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
